// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel datapath: two line buffers feed a 3x3 shift window,
// and each interior window produces one registered, saturated edge magnitude.

module sobel_core #(
  parameter int PW = 8
) (
  input  logic [3*PW-1:0] vector0_i,
  input  logic [3*PW-1:0] vector1_i,
  input  logic [3*PW-1:0] vector2_i,
  output logic [PW-1:0]   mag_o
);
  // Four extra bits hold the +-4*max gradient plus its sign.
  localparam int SW = PW + 4;
  localparam logic [SW-1:0] MAXV = SW'((1 << PW) - 1);

  logic [3*PW-1:0]        vec [3];
  logic signed [SW-1:0]   p [3][3];
  logic signed [SW-1:0]   gx, gy;
  logic [SW-1:0]          ax, ay, sum;

  assign vec[0] = vector0_i;
  assign vec[1] = vector1_i;
  assign vec[2] = vector2_i;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign p[gi][gj] = SW'(vec[gi][gj*PW +: PW]);
    end
  end

  assign gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
  assign gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
  assign ax = gx[SW-1] ? -gx : gx;
  assign ay = gy[SW-1] ? -gy : gy;
  assign sum = ax + ay;
  assign mag_o = (sum > MAXV) ? '1 : sum[PW-1:0];
endmodule

module sobel_window_ctrl #(
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic [PIXEL_WIDTH-1:0] pix_i,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  output logic [PIXEL_WIDTH-1:0] sobel_o,
  output logic                   sobel_valid_o,
  input  logic                   sobel_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int PW = PIXEL_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   sobel_q;
  logic            sobel_valid_q;
  logic [PW-1:0]   linebuf0 [IMG_W];
  logic [PW-1:0]   linebuf1 [IMG_W];
  logic [PW-1:0]   win_q [3][3];
  logic [PW-1:0]   win_d [3][3];
  logic [PW-1:0]   core_mag;
  logic            accept, last_col, last_pix, interior;

  assign pix_ready_o   = (state_q == RUN) && (!sobel_valid_q || sobel_ready_i);
  assign accept        = pix_valid_i && pix_ready_o;
  assign last_col      = (col_q == CW'(IMG_W - 1));
  assign last_pix      = last_col && (row_q == RW'(IMG_H - 1));
  // Columns 0 and 1 only prime the window, so no output ever spans two lines.
  assign interior      = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign sobel_o       = sobel_q;
  assign sobel_valid_o = sobel_valid_q;
  assign busy_o        = (state_q != IDLE);

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = linebuf0[col_q];
    win_d[1][2] = linebuf1[col_q];
    win_d[2][2] = pix_i;
  end

  // The core sees the post-shift window so the result registers on the accept edge.
  sobel_core #(.PW(PW)) u_core (
    .vector0_i ({win_d[0][2], win_d[0][1], win_d[0][0]}),
    .vector1_i ({win_d[1][2], win_d[1][1], win_d[1][0]}),
    .vector2_i ({win_d[2][2], win_d[2][1], win_d[2][0]}),
    .mag_o     (core_mag)
  );

  always_ff @(posedge clk_i) begin
    if (accept) begin
      win_q           <= win_d;
      linebuf0[col_q] <= linebuf1[col_q];
      linebuf1[col_q] <= pix_i;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_pix) begin
            state_d = DRAIN;
            row_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (!sobel_valid_q || sobel_ready_i) begin
          state_d = IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      sobel_q       <= '0;
      sobel_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (accept && interior) begin
        sobel_valid_q <= 1'b1;
        sobel_q       <= core_mag;
      end else if (sobel_ready_i) begin
        sobel_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed frames through sobel_window_ctrl (4x4) with a reference Sobel model
// feeding an expected-output queue that is drained as outputs are accepted.

module tb_sobel_window_ctrl;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk_i = 1'b0;
  logic       nreset_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] pix_i = '0;
  logic       pix_valid_i = 1'b0;
  logic       sobel_ready_i = 1'b0;
  logic       pix_ready_o;
  logic [7:0] sobel_o;
  logic       sobel_valid_o;
  logic       busy_o;
  logic       done_o;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIXEL_WIDTH(8)) dut (
    .clk_i         (clk_i),
    .nreset_i      (nreset_i),
    .start_i       (start_i),
    .pix_i         (pix_i),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
    .sobel_o       (sobel_o),
    .sobel_valid_o (sobel_valid_o),
    .sobel_ready_i (sobel_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int img[H][W];
  int br, bc, accepted, outs, dones;
  logic       held = 1'b0;
  logic [7:0] held_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pix_for(input int pat, input int r, input int c);
    case (pat)
      0: return 8'd100;
      1: return (c >= 2) ? 8'd255 : 8'd0;
      2: return 8'(c * 10);
      default: return 8'((r * 37 + c * 91 + 11) % 256);
    endcase
  endfunction

  function automatic int sobel_ref(input int r, input int c);
    int gx = 0, gy = 0, w, mag;
    for (int k = 0; k < 3; k++) begin
      w = (k == 1) ? 2 : 1;
      gx += w * (img[r-2+k][c] - img[r-2+k][c-2]);
      gy += w * (img[r][c-2+k] - img[r-2][c-2+k]);
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  task automatic step(input logic v, input logic [7:0] p, input logic rdy, input logic st);
    @(negedge clk_i);
    pix_valid_i = v;
    pix_i = p;
    sobel_ready_i = rdy;
    start_i = st;
    #1;
    if (held) begin
      check("hold_valid", sobel_valid_o, 1);
      check("hold_stable", sobel_o, held_val);
    end
    held = sobel_valid_o && !sobel_ready_i;
    held_val = sobel_o;
    if (held) check("ready_low_when_held", pix_ready_o, 0);
    if (sobel_valid_o && sobel_ready_i) begin
      outs++;
      if (exp_q.size() == 0) begin
        check("unexpected_output_queue_size", exp_q.size(), 1);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("output %0d: sobel_o=%0d expected=%0d", outs, sobel_o, e);
        check($sformatf("out%0d", outs), sobel_o, e);
      end
    end
    if (done_o) dones++;
    if (pix_valid_i && pix_ready_o) begin
      img[br][bc] = int'(p);
      if (br >= 2 && bc >= 2) exp_q.push_back(sobel_ref(br, bc));
      accepted++;
      if (bc == W - 1) begin
        bc = 0;
        br++;
      end else begin
        bc++;
      end
    end
  endtask

  task automatic run_frame(input int pat, input bit toggle, input bit start_mid, input int stop_after);
    br = 0; bc = 0; accepted = 0; outs = 0; dones = 0;
    exp_q.delete();
    step(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 400 && accepted < W * H && !(stop_after >= 0 && accepted >= stop_after); i++) begin
      step(1'b1, pix_for(pat, br, bc), toggle ? ((i % 2) == 0) : 1'b1,
           start_mid && (accepted == 5));
      if (i == 0) check("busy_in_run", busy_o, 1);
    end
    if (stop_after >= 0) return;
    check("all_pixels_accepted", accepted, W * H);
    for (int i = 0; i < 100 && dones == 0; i++)
      step(1'b0, 8'd0, toggle ? ((i % 2) == 0) : 1'b1, 1'b0);
    check("done_seen", dones, 1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("done_single_pulse", dones, 1);
    check("busy_low_after", busy_o, 0);
    check("output_count", outs, (W - 2) * (H - 2));
    check("queue_empty", exp_q.size(), 0);
    $display("frame pat=%0d toggle=%0d start_mid=%0d outputs=%0d", pat, toggle, start_mid, outs);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, sobel_valid_o, 0);
    check({tag, "_sobel"}, sobel_o, 0);
    check({tag, "_ready"}, pix_ready_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    reset_checks("por");
    @(negedge clk_i);
    nreset_i = 1'b1;
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("idle_no_ready", pix_ready_o, 0);

    run_frame(0, 1'b0, 1'b0, -1);   // flat: all zero
    run_frame(1, 1'b0, 1'b0, -1);   // vertical edge: saturates to 255
    run_frame(2, 1'b0, 1'b0, -1);   // ramp: 80
    run_frame(2, 1'b1, 1'b0, -1);   // ramp under 1010 backpressure
    run_frame(3, 1'b0, 1'b1, -1);   // irregular pixels, start pulsed mid-frame
    run_frame(1, 1'b1, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, -1);   // flat right after edge: no stale window data

    run_frame(2, 1'b0, 1'b0, 7);
    @(negedge clk_i);
    pix_valid_i = 1'b0;
    nreset_i = 1'b0;
    held = 1'b0;
    #1;
    reset_checks("midframe_reset");
    @(negedge clk_i);
    #1;
    reset_checks("reset_held");
    @(negedge clk_i);
    nreset_i = 1'b1;
    run_frame(2, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
